// File: rtl/sim_status_monitor_pkg.sv
// Shared types and default mailbox constants for the end-of-test status monitor.
// Pure declarations: no logic, no latency, no flow control.
package sim_status_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RUN     = 3'd1,
      PASS    = 3'd2,
      FAIL    = 3'd3,
      HALT    = 3'd4,
      TIMEOUT = 3'd5
   } status_e;

   localparam logic [31:0] DEF_PASS_ADDR      = 32'h0000_0064;
   localparam logic [31:0] DEF_PASS_VALUE     = 32'd7;
   localparam logic [31:0] DEF_FAIL_ADDR      = 32'h0000_0068;
   localparam int          DEF_TIMEOUT_CYCLES = 1000;
   localparam int          DEF_HALT_REPEAT    = 4;
   localparam int          DEF_CNT_W          = 32;

   function automatic logic is_terminal(input status_e s);
      return (s == PASS) || (s == FAIL) || (s == HALT) || (s == TIMEOUT);
   endfunction

endpackage

// File: rtl/sim_status_monitor_if.sv
// Core-side observation bus: data-memory write port plus program counter.
// Passive taps of the core; no handshake and no backpressure.
interface sim_status_monitor_if;

   logic        MemWrite;
   logic [31:0] DataAdr;
   logic [31:0] WriteData;
   logic [31:0] PC;

   modport master (
      output MemWrite,
      output DataAdr,
      output WriteData,
      output PC
   );

   modport slave (
      input MemWrite,
      input DataAdr,
      input WriteData,
      input PC
   );

endinterface

// File: rtl/sim_status_monitor_pc_halt_detector.sv
// Flags a "b ." loop: PC unchanged for HALT_REPEAT consecutive comparisons.
// halted is combinational on current PC vs registered history; no backpressure.
module pc_halt_detector #(
   parameter int HALT_REPEAT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [31:0] PC,
   output logic        halted
);

   localparam int            CW      = (HALT_REPEAT > 2) ? $clog2(HALT_REPEAT) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(HALT_REPEAT - 1);

   logic [31:0]   r_prev_pc;
   logic [CW-1:0] r_same_cnt;
   logic          w_same;

   assign w_same = (PC == r_prev_pc);

   // The previous PC is tracked even while disabled so the first enabled
   // cycle compares against the PC seen just before it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_prev_pc  <= 32'd0;
         r_same_cnt <= '0;
      end else begin
         r_prev_pc <= PC;
         if (en) begin
            if (!w_same) begin
               r_same_cnt <= '0;
            end else if (r_same_cnt != CNT_MAX) begin
               r_same_cnt <= r_same_cnt + CW'(1);
            end
         end
      end
   end

   assign halted = en && w_same && (r_same_cnt == CNT_MAX);

endmodule

// File: rtl/sim_status_monitor.sv
// End-of-test monitor: decodes pass/fail mailbox writes, halt loops and timeout into a sticky verdict.
// All outputs registered, verdict visible one cycle after the triggering input; passive, no backpressure.
module sim_status_monitor
   import sim_status_pkg::*;
#(
   parameter logic [31:0] PASS_ADDR      = DEF_PASS_ADDR,
   parameter logic [31:0] PASS_VALUE     = DEF_PASS_VALUE,
   parameter logic [31:0] FAIL_ADDR      = DEF_FAIL_ADDR,
   parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int          HALT_REPEAT    = DEF_HALT_REPEAT,
   parameter int          CNT_W          = DEF_CNT_W
) (
   input  logic                 clk,
   input  logic                 reset,
   sim_status_monitor_if.slave  bus,
   output logic                 done,
   output logic                 pass,
   output logic [2:0]           status,
   output logic [CNT_W-1:0]     cycle_count,
   output logic [CNT_W-1:0]     write_count,
   output logic [31:0]          fail_data
);

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

   status_e          r_state;
   status_e          w_next_state;
   logic             r_done;
   logic             r_pass;
   logic [CNT_W-1:0] r_cycle_count;
   logic [CNT_W-1:0] r_write_count;
   logic [31:0]      r_fail_data;

   logic w_run;
   logic w_halted;
   logic w_pass_hit;
   logic w_fail_hit;
   logic w_timeout_hit;
   logic w_cyc_inc;
   logic w_wr_inc;
   logic w_fail_cap;

   assign w_run = (r_state == RUN);

   pc_halt_detector #(
      .HALT_REPEAT (HALT_REPEAT)
   ) u_halt (
      .clk    (clk),
      .reset  (reset),
      .en     (w_run),
      .PC     (bus.PC),
      .halted (w_halted)
   );

   // Full 32-bit address match; a wrong value at the pass mailbox is a failure.
   assign w_pass_hit    = bus.MemWrite && (bus.DataAdr == PASS_ADDR) && (bus.WriteData == PASS_VALUE);
   assign w_fail_hit    = bus.MemWrite &&
                          (((bus.DataAdr == PASS_ADDR) && (bus.WriteData != PASS_VALUE)) ||
                           (bus.DataAdr == FAIL_ADDR));
   assign w_timeout_hit = (r_cycle_count == TO_LAST);

   always_comb begin
      w_next_state = r_state;
      w_cyc_inc    = 1'b0;
      w_wr_inc     = 1'b0;
      w_fail_cap   = 1'b0;
      case (r_state)
         IDLE: begin
            w_next_state = RUN;
         end
         RUN: begin
            w_cyc_inc = 1'b1;
            w_wr_inc  = bus.MemWrite;
            if (w_pass_hit) begin
               w_next_state = PASS;
            end else if (w_fail_hit) begin
               w_next_state = FAIL;
               w_fail_cap   = 1'b1;
            end else if (w_halted) begin
               w_next_state = HALT;
            end else if (w_timeout_hit) begin
               w_next_state = TIMEOUT;
            end
         end
         default: begin
            w_next_state = r_state;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= IDLE;
         r_done        <= 1'b0;
         r_pass        <= 1'b0;
         r_cycle_count <= '0;
         r_write_count <= '0;
         r_fail_data   <= 32'd0;
      end else begin
         r_state <= w_next_state;
         r_done  <= is_terminal(w_next_state);
         r_pass  <= (w_next_state == PASS);
         if (w_cyc_inc && (r_cycle_count != CNT_SAT)) begin
            r_cycle_count <= r_cycle_count + CNT_W'(1);
         end
         if (w_wr_inc && (r_write_count != CNT_SAT)) begin
            r_write_count <= r_write_count + CNT_W'(1);
         end
         if (w_fail_cap) begin
            r_fail_data <= bus.WriteData;
         end
      end
   end

   assign status      = r_state;
   assign done        = r_done;
   assign pass        = r_pass;
   assign cycle_count = r_cycle_count;
   assign write_count = r_write_count;
   assign fail_data   = r_fail_data;

endmodule

// File: tb/tb_sim_status_monitor.sv
// Scenario bench for sim_status_monitor: expected status snapshots are queued as stimulus is
// driven and compared one cycle later against the registered outputs.
module tb_sim_status_monitor;
   import sim_status_pkg::*;

   typedef struct packed {
      logic [2:0]  st;
      logic        dn;
      logic        ps;
      logic [31:0] cc;
      logic [31:0] wc;
      logic [31:0] fd;
   } snap_t;

   logic        clk;
   logic        reset;
   logic        done;
   logic        pass;
   logic [2:0]  status;
   logic [31:0] cycle_count;
   logic [31:0] write_count;
   logic [31:0] fail_data;

   sim_status_monitor_if bus_if ();

   sim_status_monitor #(
      .TIMEOUT_CYCLES (10),
      .HALT_REPEAT    (4)
   ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus_if),
      .done        (done),
      .pass        (pass),
      .status      (status),
      .cycle_count (cycle_count),
      .write_count (write_count),
      .fail_data   (fail_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   snap_t sb[$];
   snap_t got;
   snap_t e;
   int    total = 0;
   int    bad   = 0;

   function automatic snap_t mk(input logic [2:0] st, input logic [31:0] cc,
                                input logic [31:0] wc, input logic [31:0] fd);
      snap_t s;
      s.st = st;
      s.dn = (st == PASS) || (st == FAIL) || (st == HALT) || (st == TIMEOUT);
      s.ps = (st == PASS);
      s.cc = cc;
      s.wc = wc;
      s.fd = fd;
      return s;
   endfunction

   function automatic snap_t observe();
      snap_t s;
      s = {status, done, pass, cycle_count, write_count, fail_data};
      return s;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic mw, input logic [31:0] a, input logic [31:0] d, input logic [31:0] pc);
      bus_if.MemWrite  = mw;
      bus_if.DataAdr   = a;
      bus_if.WriteData = d;
      bus_if.PC        = pc;
   endtask

   // Leaves the DUT in RUN with cycle_count==0 visible; PC 0x100 is the value seen in IDLE.
   task automatic start_run();
      reset = 1'b1;
      drive(1'b0, 32'd0, 32'd0, 32'h100);
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1'b1, 32'h64, 32'd7, 32'h0);
      sb.push_back(mk(IDLE, 0, 0, 0));
      tick();
      got = observe(); e = sb.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL reset_idle got=%h exp=%h", got, e); end
      reset = 1'b0;
      drive(1'b0, 32'd0, 32'd0, 32'h0);
      sb.push_back(mk(RUN, 0, 0, 0));
      tick();
      got = observe(); e = sb.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL idle_to_run got=%h exp=%h", got, e); end
   endtask

   task automatic test_pass();
      start_run();
      for (int c = 0; c < 6; c++) begin
         case (c)
            2:       drive(1'b0, 32'h64, 32'd7, 32'(4 * c));
            3:       drive(1'b1, 32'h66, 32'd7, 32'(4 * c));
            5:       drive(1'b1, 32'h64, 32'd7, 32'(4 * c));
            default: drive(1'b0, 32'h0, 32'd0, 32'(4 * c));
         endcase
         if (c == 5) sb.push_back(mk(PASS, 6, 2, 0));
         else        sb.push_back(mk(RUN, 32'(c + 1), (c >= 3) ? 32'd1 : 32'd0, 0));
         tick();
         got = observe(); e = sb.pop_front(); total++;
         if (got !== e) begin bad++; $display("FAIL pass_run c=%0d got=%h exp=%h", c, got, e); end
      end
      for (int h = 0; h < 20; h++) begin
         drive(1'b1, h[0] ? 32'h68 : 32'h64, 32'(h), 32'(4 * (6 + h)));
         sb.push_back(mk(PASS, 6, 2, 0));
         tick();
         got = observe(); e = sb.pop_front(); total++;
         if (got !== e) begin bad++; $display("FAIL pass_hold h=%0d got=%h exp=%h", h, got, e); end
      end
   endtask

   task automatic test_fail();
      start_run();
      for (int c = 0; c < 3; c++) begin
         if (c == 2) drive(1'b1, 32'h64, 32'd5, 32'(4 * c));
         else        drive(1'b0, 32'h0, 32'd0, 32'(4 * c));
         if (c == 2) sb.push_back(mk(FAIL, 3, 1, 5));
         else        sb.push_back(mk(RUN, 32'(c + 1), 0, 0));
         tick();
         got = observe(); e = sb.pop_front(); total++;
         if (got !== e) begin bad++; $display("FAIL fail_value c=%0d got=%h exp=%h", c, got, e); end
      end
      drive(1'b1, 32'h64, 32'd7, 32'd12);
      sb.push_back(mk(FAIL, 3, 1, 5));
      tick();
      got = observe(); e = sb.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL fail_sticky_pass got=%h exp=%h", got, e); end
      drive(1'b1, 32'h68, 32'h1234, 32'd16);
      sb.push_back(mk(FAIL, 3, 1, 5));
      tick();
      got = observe(); e = sb.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL fail_sticky_fail got=%h exp=%h", got, e); end
   endtask

   task automatic test_fail_beats_halt();
      start_run();
      for (int c = 0; c < 5; c++) begin
         if (c == 4) drive(1'b1, 32'h68, 32'hDEAD_BEEF, 32'h10);
         else        drive(1'b0, 32'h0, 32'd0, 32'h10);
         if (c == 4) sb.push_back(mk(FAIL, 5, 1, 32'hDEAD_BEEF));
         else        sb.push_back(mk(RUN, 32'(c + 1), 0, 0));
         tick();
         got = observe(); e = sb.pop_front(); total++;
         if (got !== e) begin bad++; $display("FAIL fail_vs_halt c=%0d got=%h exp=%h", c, got, e); end
      end
   endtask

   task automatic test_halt();
      // PC toggle at cycle 3 restarts the equal-PC count.
      start_run();
      for (int c = 0; c < 9; c++) begin
         drive(1'b0, 32'h0, 32'd0, (c == 3) ? 32'h14 : 32'h10);
         if (c == 8) sb.push_back(mk(HALT, 9, 0, 0));
         else        sb.push_back(mk(RUN, 32'(c + 1), 0, 0));
         tick();
         got = observe(); e = sb.pop_front(); total++;
         if (got !== e) begin bad++; $display("FAIL halt_toggle c=%0d got=%h exp=%h", c, got, e); end
      end
      // PC parked at 0x10 from cycle 3.
      start_run();
      for (int c = 0; c < 8; c++) begin
         drive(1'b0, 32'h0, 32'd0, (c < 3) ? 32'(4 * c) : 32'h10);
         if (c == 7) sb.push_back(mk(HALT, 8, 0, 0));
         else        sb.push_back(mk(RUN, 32'(c + 1), 0, 0));
         tick();
         got = observe(); e = sb.pop_front(); total++;
         if (got !== e) begin bad++; $display("FAIL halt_park c=%0d got=%h exp=%h", c, got, e); end
      end
      for (int h = 0; h < 3; h++) begin
         drive(1'b1, 32'h64, 32'd7, 32'(h * 8));
         sb.push_back(mk(HALT, 8, 0, 0));
         tick();
         got = observe(); e = sb.pop_front(); total++;
         if (got !== e) begin bad++; $display("FAIL halt_hold h=%0d got=%h exp=%h", h, got, e); end
      end
      // Halt completes on the same cycle the timeout would fire.
      start_run();
      for (int c = 0; c < 10; c++) begin
         drive(1'b0, 32'h0, 32'd0, (c < 5) ? 32'(4 * c) : 32'h40);
         if (c == 9) sb.push_back(mk(HALT, 10, 0, 0));
         else        sb.push_back(mk(RUN, 32'(c + 1), 0, 0));
         tick();
         got = observe(); e = sb.pop_front(); total++;
         if (got !== e) begin bad++; $display("FAIL halt_vs_timeout c=%0d got=%h exp=%h", c, got, e); end
      end
   endtask

   task automatic test_timeout();
      start_run();
      for (int c = 0; c < 10; c++) begin
         drive(1'b0, 32'h0, 32'd0, 32'(4 * c));
         if (c == 9) sb.push_back(mk(TIMEOUT, 10, 0, 0));
         else        sb.push_back(mk(RUN, 32'(c + 1), 0, 0));
         tick();
         got = observe(); e = sb.pop_front(); total++;
         if (got !== e) begin bad++; $display("FAIL timeout_run c=%0d got=%h exp=%h", c, got, e); end
      end
      for (int h = 0; h < 5; h++) begin
         drive(1'b1, 32'h64, 32'd7, 32'(40 + 4 * h));
         sb.push_back(mk(TIMEOUT, 10, 0, 0));
         tick();
         got = observe(); e = sb.pop_front(); total++;
         if (got !== e) begin bad++; $display("FAIL timeout_hold h=%0d got=%h exp=%h", h, got, e); end
      end
      reset = 1'b1;
      sb.push_back(mk(IDLE, 0, 0, 0));
      tick();
      got = observe(); e = sb.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL timeout_reset got=%h exp=%h", got, e); end
      reset = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      start_run();
      for (int c = 0; c < 7; c++) begin
         drive((c == 1) || (c == 3) || (c == 5), 32'h200, 32'(c), 32'(4 * c));
         sb.push_back(mk(RUN, 32'(c + 1), (c >= 5) ? 32'd3 : (c >= 3) ? 32'd2 : (c >= 1) ? 32'd1 : 32'd0, 0));
         tick();
         got = observe(); e = sb.pop_front(); total++;
         if (got !== e) begin bad++; $display("FAIL midrun_count c=%0d got=%h exp=%h", c, got, e); end
      end
      reset = 1'b1;
      drive(1'b1, 32'h64, 32'd7, 32'd28);
      sb.push_back(mk(IDLE, 0, 0, 0));
      tick();
      got = observe(); e = sb.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL midrun_reset got=%h exp=%h", got, e); end
      reset = 1'b0;
      drive(1'b0, 32'h0, 32'd0, 32'd0);
      sb.push_back(mk(RUN, 0, 0, 0));
      tick();
      got = observe(); e = sb.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL midrun_rerun got=%h exp=%h", got, e); end
      drive(1'b1, 32'h200, 32'd9, 32'd4);
      sb.push_back(mk(RUN, 1, 1, 0));
      tick();
      got = observe(); e = sb.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL midrun_restart got=%h exp=%h", got, e); end
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, 32'h0, 32'd0, 32'h0);
      test_reset();
      test_pass();
      test_fail();
      test_fail_beats_halt();
      test_halt();
      test_timeout();
      test_reset_mid_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sim_status_monitor.md
Name: sim_status_monitor

Overview:
Synthesizable end-of-test monitor that sits directly downstream of the single-cycle ARM top. It consumes the core's data-memory write bus (DataAdr, WriteData, MemWrite) and PC, and produces a registered pass/fail/halt/timeout verdict. Benches and FPGA builds read one status word, so each test program needs no hand-written checker.

Parameters:
PASS_ADDR, 32'h0000_0064, byte address of the pass mailbox.
PASS_VALUE, 32'd7, value that signals success when written to PASS_ADDR.
FAIL_ADDR, 32'h0000_0068, any write here signals failure.
TIMEOUT_CYCLES, 1000, number of RUN cycles allowed before the TIMEOUT verdict; must be >= 2.
HALT_REPEAT, 4, consecutive cycles with an unchanged PC that count as a halt loop ("b ."); must be >= 2.
CNT_W, 32, width of the cycle and write counters.

Ports:
clk  in  1  system clock; all logic on posedge.
reset  in  1  synchronous, active-high reset.
MemWrite  in  1  core data-memory write enable.
DataAdr  in  32  core data-memory byte address.
WriteData  in  32  core data-memory write data.
PC  in  32  core program counter.
done  out  1  high in any terminal state.
pass  out  1  high only in PASS.
status  out  3  current state encoding (see package).
cycle_count  out  CNT_W  RUN cycles elapsed.
write_count  out  CNT_W  MemWrite cycles seen in RUN.
fail_data  out  32  WriteData captured on the FAIL trigger.

Behaviour:
- Interface: one clock (clk). reset is synchronous and active-high. All outputs are registered.
- Reset values: status=IDLE, done=0, pass=0, cycle_count=0, write_count=0, fail_data=0, and internal same-PC counter=0.
- Reset asserted in any state, including mid-run or terminal, returns to the reset values on the next posedge.
- IDLE -> RUN on the first posedge with reset=0. No events are sampled in IDLE.
- RUN, per posedge (evaluated on current inputs; result visible one cycle later):
  - cycle_count += 1, saturating at all-ones.
  - If MemWrite, write_count += 1, saturating.
  - PASS if MemWrite && DataAdr==PASS_ADDR && WriteData==PASS_VALUE.
  - FAIL if MemWrite && DataAdr==PASS_ADDR && WriteData!=PASS_VALUE, or if MemWrite && DataAdr==FAIL_ADDR. On FAIL, fail_data<=WriteData.
  - HALT if the same-PC counter reaches HALT_REPEAT-1 and PC==previous PC.
  - TIMEOUT if cycle_count==TIMEOUT_CYCLES-1.
- Priority when events coincide: PASS/FAIL write > HALT > TIMEOUT.
- Same-PC counter:
  - Compares PC to PC registered on the previous cycle.
  - Increments when equal; clears to 0 on any change.
  - Saturates at HALT_REPEAT-1.
  - First RUN cycle compares against the PC captured in IDLE.
- Terminal states (PASS, FAIL, HALT, TIMEOUT) are sticky until reset. In a terminal state:
  - All counters and fail_data are frozen.
  - Further writes are ignored, including a PASS write after FAIL.
- done = status in {PASS, FAIL, HALT, TIMEOUT}; pass = (status==PASS). Both are registered together with status.
- Address compare is on the full 32 bits; there is no word-alignment masking.

Decomposition:
- Package sim_status_pkg:
  - status_e, 3-bit enum: IDLE=0, RUN=1, PASS=2, FAIL=3, HALT=4, TIMEOUT=5.
  - Default mailbox address and value constants.
- Sub-module pc_halt_detector (clk, reset, en, PC -> halted): owns the previous-PC register and the saturating same-PC counter, parameterized by HALT_REPEAT.
- The top level holds the FSM, counters and mailbox decode.

Test Plan:
- Reset for 1 cycle, then PC increments by 4 each cycle and one write of 7 to 0x64 at RUN cycle 5 -> next cycle status=PASS, done=1, pass=1, cycle_count=6, write_count=1; values hold for 20 more cycles.
- Write of 5 to 0x64 -> status=FAIL, fail_data=5, pass=0. A later write of 7 to 0x64 leaves FAIL.
- Write of 0xDEAD_BEEF to 0x68 in the same cycle PC would complete the halt count -> FAIL wins, fail_data=0xDEAD_BEEF.
- PC held at 0x10 from RUN cycle 3 with no writes, HALT_REPEAT=4 -> status=HALT after 4 equal-PC cycles. A PC toggle before that resets the count.
- TIMEOUT_CYCLES=10, PC incrementing, no mailbox writes -> status=TIMEOUT with cycle_count=10, then frozen.
- Reset asserted for 1 cycle while in RUN at cycle 7 with write_count=3 -> all outputs return to reset values, IDLE -> RUN, and counters restart from 0.
